// File: rtl/bpsk_pkg.sv
// bpsk_pkg: shared frame-controller state encoding and default parameters
package bpsk_pkg;
  typedef enum logic [1:0] {IDLE, PRE, SYNC, DATA} state_t;
  localparam int SPS_DEF = 8;
  localparam int PRE_LEN_DEF = 16;
  localparam logic [7:0] SYNC_WORD_DEF = 8'hD3;
endpackage

// File: rtl/bpsk_sym_timer.sv
// bpsk_sym_timer: symbol counter 0..SPS-1 while run; strobe on count 0, sym_end on count SPS-1
module bpsk_sym_timer import bpsk_pkg::*; #(
  parameter int SPS = SPS_DEF
) (
  input  logic clk_sig,
  input  logic rst,
  input  logic run,
  output logic strobe,
  output logic sym_end
);
  logic [7:0] cnt;
  assign strobe = run && cnt == 8'd0;
  assign sym_end = run && cnt == 8'(SPS - 1);
  always_ff @(posedge clk_sig)
    cnt <= (rst || !run || sym_end) ? 8'd0 : cnt + 8'd1;
endmodule

// File: rtl/bpsk_frame_ctrl.sv
// bpsk_frame_ctrl: BPSK framer (preamble, sync word, payload bytes MSB first) with 1-entry byte buffer; in_* byte handshake, base_sig/sym_strobe/tx_active/done/underrun to modulator
module bpsk_frame_ctrl import bpsk_pkg::*; #(
  parameter int SPS = SPS_DEF,
  parameter int PRE_LEN = PRE_LEN_DEF,
  parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEF
) (
  input  logic       clk_sig,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       in_ready,
  output logic       base_sig,
  output logic       sym_strobe,
  output logic       tx_active,
  output logic       done,
  output logic       underrun
);
  state_t state, state_n;
  logic buf_full, buf_last, cur_last, cur_last_n, base_n, sym_end, bnd, fin, und, load;
  logic [7:0] buf_data, sh, sh_n, idx, idx_n;
  bpsk_sym_timer #(.SPS(SPS)) u_tmr (
    .clk_sig(clk_sig),
    .rst(rst),
    .run(state != IDLE),
    .strobe(sym_strobe),
    .sym_end(sym_end)
  );
  assign in_ready = ~buf_full & ~rst;
  assign tx_active = state != IDLE;
  always_comb begin
    bnd = sym_end && (state == SYNC || state == DATA) && idx == 8'd7;
    fin = bnd && cur_last;
    load = bnd && !cur_last && buf_full;
    und = bnd && !cur_last && !buf_full;
    state_n = state;
    idx_n = idx;
    sh_n = sh;
    cur_last_n = cur_last;
    base_n = base_sig;
    if (state == IDLE && buf_full) begin
      state_n = PRE;
      idx_n = 8'd0;
      base_n = 1'b1;
    end else if (sym_end && state == PRE) begin
      if (idx == 8'(PRE_LEN - 1)) begin
        state_n = SYNC;
        idx_n = 8'd0;
        sh_n = SYNC_WORD;
        cur_last_n = 1'b0;
        base_n = SYNC_WORD[7];
      end else begin
        idx_n = idx + 8'd1;
        base_n = idx[0];
      end
    end else if (load) begin
      state_n = DATA;
      idx_n = 8'd0;
      sh_n = buf_data;
      cur_last_n = buf_last;
      base_n = buf_data[7];
    end else if (fin || und) begin
      state_n = IDLE;
      base_n = 1'b0;
    end else if (sym_end) begin
      idx_n = idx + 8'd1;
      sh_n = {sh[6:0], 1'b0};
      base_n = sh[6];
    end
  end
  always_ff @(posedge clk_sig)
    if (rst) begin
      state <= IDLE;
      idx <= 8'd0;
      sh <= 8'd0;
      cur_last <= 1'b0;
      base_sig <= 1'b0;
      buf_full <= 1'b0;
      buf_data <= 8'd0;
      buf_last <= 1'b0;
      done <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      sh <= sh_n;
      cur_last <= cur_last_n;
      base_sig <= base_n;
      done <= fin;
      underrun <= und;
      if (in_valid && in_ready) begin
        buf_full <= 1'b1;
        buf_data <= in_data;
        buf_last <= in_last;
      end else if (load) buf_full <= 1'b0;
    end
endmodule

// File: tb/tb_bpsk_frame_ctrl.sv
// tb_bpsk_frame_ctrl: scoreboard bench for bpsk_frame_ctrl at SPS=4/PRE_LEN=4 and SPS=2/PRE_LEN=2
module tb_bpsk_frame_ctrl;
  logic clk_sig = 1'b0;
  always #5 clk_sig = ~clk_sig;
  logic rst, in_valid, in_last, in_ready, base_sig, sym_strobe, tx_active, done, underrun;
  logic in_valid2, in_last2, in_ready2, base_sig2, sym_strobe2, tx_active2, done2, underrun2;
  logic [7:0] in_data, in_data2;
  int n_vec = 0, n_err = 0;
  bit exp_q[$], exp_q2[$];
  int act_cnt = 0, act_cnt2 = 0, n_done = 0, n_und = 0, n_done2 = 0, n_acc = 0, exp_len = 0;
  logic acc_strobe, prev_base = 1'b0;
  bit exp_kind = 1'b1;

  bpsk_frame_ctrl #(.SPS(4), .PRE_LEN(4), .SYNC_WORD(8'hD3)) u_dut (
    .clk_sig(clk_sig), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .base_sig(base_sig), .sym_strobe(sym_strobe), .tx_active(tx_active),
    .done(done), .underrun(underrun)
  );
  bpsk_frame_ctrl #(.SPS(2), .PRE_LEN(2), .SYNC_WORD(8'hD3)) u_dut2 (
    .clk_sig(clk_sig), .rst(rst), .in_valid(in_valid2), .in_data(in_data2), .in_last(in_last2),
    .in_ready(in_ready2), .base_sig(base_sig2), .sym_strobe(sym_strobe2), .tx_active(tx_active2),
    .done(done2), .underrun(underrun2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_bit(input bit b, input bit sel);
    if (sel) exp_q2.push_back(b);
    else exp_q.push_back(b);
  endtask

  task automatic push_byte(input logic [7:0] b, input bit sel);
    for (int i = 7; i >= 0; i--) push_bit(b[i], sel);
  endtask

  task automatic push_hdr(input int pre, input bit sel);
    for (int i = 0; i < pre; i++) push_bit(i % 2 == 0, sel);
    push_byte(8'hD3, sel);
  endtask

  task automatic send_byte(input logic [7:0] d, input bit l, input bit sel);
    bit ok = 1'b0;
    if (sel) begin in_valid2 = 1'b1; in_data2 = d; in_last2 = l; end
    else begin in_valid = 1'b1; in_data = d; in_last = l; end
    for (int k = 0; k < 400 && !ok; k++) begin
      @(negedge clk_sig);
      ok = sel ? in_ready2 : in_ready;
      if (ok) acc_strobe = sel ? sym_strobe2 : sym_strobe;
      @(posedge clk_sig);
      #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_end(input int budget, input bit sel);
    bit hit = 1'b0;
    for (int k = 0; k < budget && !hit; k++) begin
      @(negedge clk_sig);
      hit = sel ? done2 : (done || underrun);
    end
    if (!hit) chk("end_timeout", 0, 1);
    @(posedge clk_sig);
    #1;
  endtask

  always @(negedge clk_sig)
    if (!rst) begin
      if (in_valid && in_ready) n_acc++;
      if (sym_strobe) begin
        chk("strobe_in_frame", tx_active, 1);
        if (exp_q.size() == 0) chk("extra_symbol", 0, 1);
        else chk("bit", base_sig, exp_q.pop_front());
      end else if (base_sig !== prev_base) chk("base_off_strobe", base_sig, (done || underrun) ? 1'b0 : prev_base);
      if (!tx_active) chk("base_idle", base_sig, 0);
      if (done || underrun) begin
        chk("end_kind", {done, underrun}, exp_kind ? 2'b10 : 2'b01);
        chk("frame_len", act_cnt, exp_len);
        chk("tx_at_end", tx_active, 0);
        if (done) n_done++;
        if (underrun) n_und++;
        act_cnt = 0;
      end
      if (tx_active) act_cnt++;
      prev_base = base_sig;
    end else begin
      act_cnt = 0;
      prev_base = 1'b0;
    end

  always @(negedge clk_sig)
    if (!rst) begin
      if (tx_active2) begin
        chk("sps2_strobe", sym_strobe2, act_cnt2 % 2 == 0);
        if (sym_strobe2) begin
          if (exp_q2.size() == 0) chk("sps2_extra", 0, 1);
          else chk("sps2_bit", base_sig2, exp_q2.pop_front());
        end
        act_cnt2++;
      end
      if (done2) begin
        chk("sps2_len", act_cnt2, 52);
        n_done2++;
        act_cnt2 = 0;
      end
    end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b1;
    {in_valid, in_last, in_data} = '0;
    {in_valid2, in_last2, in_data2} = '0;
    repeat (3) @(posedge clk_sig);
    #1;
    chk("rst_ready", in_ready, 0);
    chk("rst_base", base_sig, 0);
    chk("rst_tx", tx_active, 0);
    chk("rst_strobe", sym_strobe, 0);
    chk("rst_done", done, 0);
    chk("rst_und", underrun, 0);
    rst = 1'b0;
    @(negedge clk_sig);
    chk("ready_after_rst", in_ready, 1);
    @(posedge clk_sig);
    #1;
    exp_len = 80;
    exp_kind = 1'b1;
    push_hdr(4, 1'b0);
    push_byte(8'hA5, 1'b0);
    send_byte(8'hA5, 1'b1, 1'b0);
    in_valid = 1'b0;
    wait_end(300, 1'b0);
    chk("single_done", n_done, 1);
    chk("single_q_empty", exp_q.size(), 0);
    n0 = n_acc;
    exp_len = 144;
    push_hdr(4, 1'b0);
    push_byte(8'h3C, 1'b0);
    push_byte(8'hC3, 1'b0);
    push_byte(8'h7E, 1'b0);
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    chk("b2b_acc2_after_load", acc_strobe, 1);
    send_byte(8'h7E, 1'b1, 1'b0);
    chk("b2b_acc3_after_load", acc_strobe, 1);
    in_valid = 1'b0;
    wait_end(400, 1'b0);
    chk("b2b_accepts", n_acc - n0, 3);
    chk("b2b_done", n_done, 2);
    chk("b2b_q_empty", exp_q.size(), 0);
    exp_len = 80;
    exp_kind = 1'b0;
    push_hdr(4, 1'b0);
    push_byte(8'h81, 1'b0);
    send_byte(8'h81, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_end(300, 1'b0);
    chk("und_pulse", n_und, 1);
    chk("und_no_done", n_done, 2);
    repeat (10) begin
      @(negedge clk_sig);
      chk("und_idle_tx", tx_active, 0);
    end
    chk("und_ready", in_ready, 1);
    chk("und_q_empty", exp_q.size(), 0);
    @(posedge clk_sig);
    #1;
    exp_kind = 1'b1;
    push_hdr(4, 1'b0);
    push_byte(8'h42, 1'b0);
    send_byte(8'h42, 1'b1, 1'b0);
    in_valid = 1'b0;
    for (int k = 0; k < 200 && act_cnt < 24; k++) @(negedge clk_sig);
    chk("reached_sync", act_cnt >= 24, 1);
    @(posedge clk_sig);
    #1;
    rst = 1'b1;
    @(posedge clk_sig);
    #1;
    chk("midrst_base", base_sig, 0);
    chk("midrst_tx", tx_active, 0);
    chk("midrst_strobe", sym_strobe, 0);
    chk("midrst_ready", in_ready, 0);
    chk("midrst_done", done, 0);
    chk("midrst_und", underrun, 0);
    exp_q.delete();
    rst = 1'b0;
    repeat (5) @(posedge clk_sig);
    #1;
    chk("midrst_no_pulse", n_done + n_und, 3);
    chk("midrst_idle", tx_active, 0);
    exp_len = 80;
    push_hdr(4, 1'b0);
    push_byte(8'hE7, 1'b0);
    send_byte(8'hE7, 1'b1, 1'b0);
    in_valid = 1'b0;
    wait_end(300, 1'b0);
    chk("restart_done", n_done, 3);
    chk("restart_q_empty", exp_q.size(), 0);
    push_hdr(2, 1'b1);
    push_byte(8'h96, 1'b1);
    push_byte(8'h5A, 1'b1);
    send_byte(8'h96, 1'b0, 1'b1);
    send_byte(8'h5A, 1'b1, 1'b1);
    in_valid2 = 1'b0;
    wait_end(300, 1'b1);
    chk("sps2_done", n_done2, 1);
    chk("sps2_q_empty", exp_q2.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bpsk_frame_ctrl.md
BPSK_FRAME_CTRL -- requirements
Module: bpsk_frame_ctrl

Interface
REQ-001 Parameter SPS, default 8: clk_sig cycles per symbol; legal range 2..255.
REQ-002 Parameter PRE_LEN, default 16: number of preamble symbols; legal range 1..255.
REQ-003 Parameter SYNC_WORD, default 8'hD3: 8-bit sync pattern sent after the preamble.
REQ-004 Port clk_sig, input, 1: single clock; all logic is clocked on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous, active-high.
REQ-006 Port in_valid, input, 1: payload byte offered.
REQ-007 Port in_data, input, 8: payload byte, sent MSB first.
REQ-008 Port in_last, input, 1: the offered byte is the last byte of the frame.
REQ-009 Port in_ready, output, 1: the block accepts a byte on a cycle where in_valid and in_ready are both high.
REQ-010 Port base_sig, output, 1: bit stream to the BPSK modulator.
REQ-011 Port sym_strobe, output, 1: one-cycle pulse on the first cycle of every transmitted symbol.
REQ-012 Port tx_active, output, 1: high from the first preamble symbol through the last data symbol.
REQ-013 Port done, output, 1: one-cycle pulse when a frame completes normally.
REQ-014 Port underrun, output, 1: one-cycle pulse when a frame is aborted because no byte is available.

Function
REQ-015 The state machine SHALL have states IDLE, PRE, SYNC, DATA; in IDLE, base_sig SHALL be 0.
REQ-016 A 1-entry holding buffer SHALL store the byte, and its last flag, on each accepted handshake.
REQ-017 in_ready SHALL equal the inverse of the buffer-full flag, in every state.
REQ-018 IDLE SHALL move to PRE on the cycle after the buffer becomes full; that cycle SHALL be symbol 0, with sym_strobe=1 and tx_active=1.
REQ-019 A symbol counter SHALL count 0..SPS-1 and wrap to 0.
  - base_sig SHALL change only on cycles where the counter is 0.
  - sym_strobe SHALL be high exactly when the counter is 0 and the state is not IDLE.
REQ-020 PRE SHALL send PRE_LEN symbols alternating 1,0,1,... starting with 1, then SHALL move to SYNC.
REQ-021 SYNC SHALL send SYNC_WORD MSB first over 8 symbols, then SHALL move to DATA.
REQ-022 At each byte boundary (DATA entry, and after the 8th bit of a byte), an 8-bit shift register SHALL load from the buffer.
  - The load SHALL free the buffer in the same cycle.
  - A simultaneous in_valid SHALL be accepted on the following cycle.
REQ-023 DATA SHALL send the shift register MSB first, one bit per symbol.
REQ-024 After the 8th bit of a byte flagged last:
  - the block SHALL return to IDLE;
  - done SHALL pulse on the cycle the final symbol period ends;
  - tx_active and base_sig SHALL drop to 0 on that same cycle.
REQ-025 Underrun: if the buffer is empty at a byte boundary in DATA (previous byte not last), the block SHALL go to IDLE, pulse underrun, and force base_sig=0.
REQ-026 The first byte SHALL be held in the buffer through PRE and SYNC; a second byte SHALL NOT be accepted until that first byte loads at DATA entry.
REQ-027 done and underrun SHALL never assert in the same cycle.
REQ-028 Total frame length SHALL be (PRE_LEN + 8 + 8*N) * SPS cycles for N payload bytes.

Reset
REQ-029 While rst=1:
  - state SHALL be IDLE;
  - the counter SHALL be 0;
  - the buffer SHALL be empty;
  - base_sig, sym_strobe, tx_active, done and underrun SHALL be 0;
  - in_ready SHALL be 0.
  After reset, in_ready SHALL be 1 on the first cycle with rst=0.
REQ-030 Reset mid-frame SHALL abort the frame immediately, with no done or underrun pulse.

Structure
REQ-031 State encodings SHALL be defined in shared package bpsk_pkg; SPS, PRE_LEN and SYNC_WORD defaults SHALL be defined there as constants.
REQ-032 The symbol timer SHALL be a sub-module, bpsk_sym_timer (counter plus strobe); the FSM, buffer and shift register SHALL be in bpsk_frame_ctrl.
REQ-033 base_sig SHALL be driven from a register.

Verification
REQ-034 SPS=4, PRE_LEN=4, one byte 8'hA5 with last=1. Required: base_sig per symbol = 1010 11010011 10100101; done at cycle 80 after the IDLE->PRE cycle; tx_active high for 80 cycles.
REQ-035 Three bytes offered back-to-back with in_valid held high. Required: each byte is accepted once, with no gap symbols between bytes; frame length is (4+8+24)*4 cycles.
REQ-036 Two bytes, where the second byte is withheld past the boundary. Required: underrun pulses at the first byte boundary after byte 1; base_sig=0 and state=IDLE afterwards; done never pulses.
REQ-037 rst=1 asserted during SYNC. Required: outputs reach reset values on the next edge; a new frame then starts cleanly from PRE.
REQ-038 in_valid=1 in the same cycle the shift register loads (buffer full). Required: in_ready=0 that cycle, accepted the next cycle, and no byte is lost or duplicated.
REQ-039 SPS=2 minimum. Required: sym_strobe toggles every other cycle and the bit order is preserved.
